// File: rtl/alu_ctl_seq_if.sv
// alu_ctl_seq request/response bundle.
// master drives requests and out_ready; slave is the decoder.
interface alu_ctl_seq_if #(
  parameter int OP_W    = 4,
  parameter int FUNCT_W = 6,
  parameter int CTL_W   = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [OP_W-1:0]    alu_op;
  logic [FUNCT_W-1:0] func_code;
  logic               out_valid;
  logic               out_ready;
  logic [CTL_W-1:0]   out_ctl;
  logic               out_muldiv;
  logic               busy;
  logic               illegal;

  modport master (
    output in_valid,
    output alu_op,
    output func_code,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_ctl,
    input  out_muldiv,
    input  busy,
    input  illegal
  );

  modport slave (
    input  in_valid,
    input  alu_op,
    input  func_code,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_ctl,
    output out_muldiv,
    output busy,
    output illegal
  );
endinterface

// File: rtl/alu_ctl_seq.sv
// Registered ALU control decoder with mult/div sequencing.
// ALU_CTL_STICKY_ERR_EN adds err_sticky (set on accepted illegal).
module alu_ctl_seq #(
  parameter int OP_W        = 4,
  parameter int FUNCT_W     = 6,
  parameter int CTL_W       = 4,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 8
) (
  input  logic clk,
  input  logic rst_n,
`ifdef ALU_CTL_STICKY_ERR_EN
  output logic err_sticky,
`endif
  alu_ctl_seq_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] MC = 8'(MULT_CYCLES - 2);
  localparam logic [7:0] DC = 8'(DIV_CYCLES - 2);

  state_t      state;
  logic [7:0]  cnt;
  logic        dv;
  logic [3:0]  d_code;
  logic        d_md;
  logic        d_ill;
  logic [31:0] op32;
  logic [31:0] f32;
  logic        xfer;

  assign op32 = 32'(bus.alu_op);
  assign f32  = 32'(bus.func_code);

  assign bus.in_ready = (state == IDLE) &&
                        (!bus.out_valid || bus.out_ready);
  assign xfer = bus.in_valid && bus.in_ready;

  always_comb begin
    d_code = 4'd15;
    d_md   = 1'b0;
    d_ill  = 1'b0;
    unique case (1'b1)
      (op32 == 32'd0): d_code = 4'd2;
      (op32 == 32'd1): d_code = 4'd6;
      (op32 == 32'd3): d_code = 4'd2;
      (op32 == 32'd4): d_code = 4'd7;
      (op32 == 32'd5): d_code = 4'd0;
      (op32 == 32'd6): d_code = 4'd1;
      (op32 == 32'd7): d_code = 4'd11;
      (op32 == 32'd2): begin
        unique case (1'b1)
          (f32 == 32'd0),
          (f32 == 32'd2),
          (f32 == 32'd8),
          (f32 == 32'd43): d_code = 4'd15;
          (f32 == 32'd32),
          (f32 == 32'd33): d_code = 4'd2;
          (f32 == 32'd34),
          (f32 == 32'd35): d_code = 4'd6;
          (f32 == 32'd36): d_code = 4'd0;
          (f32 == 32'd37): d_code = 4'd1;
          (f32 == 32'd39): d_code = 4'd12;
          (f32 == 32'd42): d_code = 4'd7;
          (f32 == 32'd24),
          (f32 == 32'd25): begin
            d_code = 4'd13;
            d_md   = 1'b1;
          end
          (f32 == 32'd26),
          (f32 == 32'd27): begin
            d_code = 4'd14;
            d_md   = 1'b1;
          end
          default: d_ill = 1'b1;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      dv             <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_ctl    <= '0;
      bus.out_muldiv <= 1'b0;
      bus.busy       <= 1'b0;
      bus.illegal    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (xfer && d_md) begin
            // funct bit 1 separates div (26/27) from mult (24/25)
            state         <= BUSY;
            bus.busy      <= 1'b1;
            dv            <= bus.func_code[1];
            cnt           <= bus.func_code[1] ? DC : MC;
            bus.out_valid <= 1'b0;
          end else if (xfer) begin
            bus.out_valid  <= 1'b1;
            bus.out_ctl    <= CTL_W'(d_code);
            bus.out_muldiv <= 1'b0;
            bus.illegal    <= d_ill;
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt == 8'd0) begin
            state          <= IDLE;
            bus.busy       <= 1'b0;
            bus.out_valid  <= 1'b1;
            bus.out_ctl    <= CTL_W'(dv ? 4'd14 : 4'd13);
            bus.out_muldiv <= 1'b1;
            bus.illegal    <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_CTL_STICKY_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_sticky <= 1'b0;
    else if (xfer && d_ill)
      err_sticky <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_alu_ctl_seq.sv
// Bench for alu_ctl_seq: directed cases plus random traffic
// against a transaction-level reference model.
module tb_alu_ctl_seq;
  localparam int OP_W    = 4;
  localparam int FUNCT_W = 6;
  localparam int CTL_W   = 4;
  localparam int MC      = 4;
  localparam int DC      = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_ctl_seq_if #(
    .OP_W(OP_W), .FUNCT_W(FUNCT_W), .CTL_W(CTL_W)
  ) bus ();

`ifdef ALU_CTL_STICKY_ERR_EN
  logic err_sticky;
`endif

  alu_ctl_seq #(
    .OP_W(OP_W), .FUNCT_W(FUNCT_W), .CTL_W(CTL_W),
    .MULT_CYCLES(MC), .DIV_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef ALU_CTL_STICKY_ERR_EN
    .err_sticky(err_sticky),
`endif
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference model state: what the consumer should see
  bit     m_ov, m_md, m_ill, m_pend, m_stk;
  int     m_ctl, m_pctl;
  longint cyc, m_due;
  bit     last_acc;

  function automatic void ref_dec(input int op, input int f,
                                  output int code,
                                  output bit md,
                                  output bit ill);
    md = 1'b0;
    ill = 1'b0;
    code = 15;
    if (op > 7) ill = 1'b1;
    else if (op == 0 || op == 3) code = 2;
    else if (op == 1) code = 6;
    else if (op == 4) code = 7;
    else if (op == 5) code = 0;
    else if (op == 6) code = 1;
    else if (op == 7) code = 11;
    else if (f inside {0, 2, 8, 43}) code = 15;
    else if (f inside {32, 33}) code = 2;
    else if (f inside {34, 35}) code = 6;
    else if (f == 36) code = 0;
    else if (f == 37) code = 1;
    else if (f == 39) code = 12;
    else if (f == 42) code = 7;
    else if (f inside {24, 25}) begin code = 13; md = 1'b1; end
    else if (f inside {26, 27}) begin code = 14; md = 1'b1; end
    else ill = 1'b1;
  endfunction

  function automatic bit exp_rdy();
    return !m_pend && (!m_ov || bus.out_ready);
  endfunction

  task automatic model_reset();
    m_ov = 0; m_md = 0; m_ill = 0; m_pend = 0; m_stk = 0;
    m_ctl = 0; m_pctl = 0; m_due = 0;
  endtask

  task automatic drive(input bit v, input int op,
                       input int f, input bit rdy);
    bus.in_valid  = v;
    bus.alu_op    = OP_W'(op);
    bus.func_code = FUNCT_W'(f);
    bus.out_ready = rdy;
    #1;
  endtask

  // One cycle: compare at negedge, advance model at posedge.
  task automatic step();
    int code;
    bit md, ill, acc;
    @(negedge clk);
    chk("in_ready", int'(bus.in_ready), int'(exp_rdy()));
    chk("out_valid", int'(bus.out_valid), int'(m_ov));
    chk("busy", int'(bus.busy), int'(m_pend));
    if (m_ov) begin
      chk("out_ctl", int'(bus.out_ctl), m_ctl);
      chk("out_muldiv", int'(bus.out_muldiv), int'(m_md));
      chk("illegal", int'(bus.illegal), int'(m_ill));
    end
`ifdef ALU_CTL_STICKY_ERR_EN
    chk("err_sticky", int'(err_sticky), int'(m_stk));
`endif
    @(posedge clk);
    last_acc = 1'b0;
    if (rst_n) begin
      acc = bus.in_valid && exp_rdy();
      last_acc = acc;
      if (m_ov && bus.out_ready) m_ov = 0;
      if (m_pend && cyc == m_due) begin
        m_ov = 1; m_ctl = m_pctl; m_md = 1;
        m_ill = 0; m_pend = 0;
      end
      if (acc) begin
        ref_dec(int'(bus.alu_op), int'(bus.func_code),
                code, md, ill);
        if (ill) m_stk = 1;
        if (md) begin
          m_pend = 1;
          m_pctl = code;
          m_due = cyc + ((code == 13) ? MC : DC) - 1;
        end else begin
          m_ov = 1; m_ctl = code; m_md = 0; m_ill = ill;
        end
      end
      cyc++;
    end
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ops[7] = '{0, 1, 3, 4, 5, 6, 7};
    int exp2[7] = '{2, 6, 2, 7, 0, 1, 11};
    int fl[16] = '{0, 2, 8, 32, 33, 34, 35, 36,
                   37, 39, 42, 43, 24, 25, 26, 27};
    int n, op, f;
    bit v;
    cyc = 0;
    last_acc = 0;
    model_reset();
    drive(0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov", int'(bus.out_valid), 0);
    chk("rst_ctl", int'(bus.out_ctl), 0);
    chk("rst_md", int'(bus.out_muldiv), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ill", int'(bus.illegal), 0);
    rst_n = 1'b1;
    step();

    // single R-type add
    drive(1, 2, 32, 1);
    step();
    drive(0, 0, 0, 1);
    chk("t1_ov", int'(bus.out_valid), 1);
    chk("t1_ctl", int'(bus.out_ctl), 2);
    chk("t1_ill", int'(bus.illegal), 0);
    chk("t1_md", int'(bus.out_muldiv), 0);
    step();

    // back-to-back I-type stream
    for (int i = 0; i < 7; i++) begin
      drive(1, ops[i], 0, 1);
      chk("t2_rdy", int'(bus.in_ready), 1);
      step();
      chk("t2_ov", int'(bus.out_valid), 1);
      chk("t2_ctl", int'(bus.out_ctl), exp2[i]);
    end
    drive(0, 0, 0, 1);
    step();

    // mult with a second request held during busy
    drive(1, 2, 24, 1);
    step();
    drive(1, 2, 32, 1);
    n = 1;
    while (!bus.out_valid && n < 20) begin
      chk("t3_rdy_busy", int'(bus.in_ready), 0);
      step();
      n++;
    end
    chk("t3_lat", n, MC);
    chk("t3_ctl", int'(bus.out_ctl), 13);
    chk("t3_md", int'(bus.out_muldiv), 1);
    chk("t3_rdy", int'(bus.in_ready), 1);
    step();
    chk("t3_2nd_ov", int'(bus.out_valid), 1);
    chk("t3_2nd_ctl", int'(bus.out_ctl), 2);
    chk("t3_2nd_md", int'(bus.out_muldiv), 0);
    drive(0, 0, 0, 1);
    step();

    // div with consumer stalled at completion
    drive(1, 2, 26, 0);
    step();
    drive(1, 2, 33, 0);
    n = 1;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    chk("t4_lat", n, DC);
    repeat (3) begin
      step();
      chk("t4_ov", int'(bus.out_valid), 1);
      chk("t4_ctl", int'(bus.out_ctl), 14);
      chk("t4_rdy", int'(bus.in_ready), 0);
    end
    drive(1, 2, 33, 1);
    step();
    chk("t4_next_ctl", int'(bus.out_ctl), 2);
    drive(0, 0, 0, 1);
    step();

    // illegal funct and illegal ALUOp
    drive(1, 2, 50, 1);
    step();
    chk("t5a_ctl", int'(bus.out_ctl), 15);
    chk("t5a_ill", int'(bus.illegal), 1);
    drive(1, 9, 0, 1);
    step();
    chk("t5b_ov", int'(bus.out_valid), 1);
    chk("t5b_ctl", int'(bus.out_ctl), 15);
    chk("t5b_ill", int'(bus.illegal), 1);
    drive(0, 0, 0, 1);
    step();
`ifdef ALU_CTL_STICKY_ERR_EN
    step();
    chk("t5_sticky", int'(err_sticky), 1);
`endif

    // reset in the middle of a div
    drive(1, 2, 27, 1);
    step();
    drive(0, 0, 0, 1);
    step();
    chk("t6_busy_pre", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy_rst", int'(bus.busy), 0);
    chk("t6_ov_rst", int'(bus.out_valid), 0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
`ifdef ALU_CTL_STICKY_ERR_EN
    chk("t6_sticky", int'(err_sticky), 0);
`endif
    repeat (12) step();
    chk("t6_rdy", int'(bus.in_ready), 1);
    chk("t6_ov", int'(bus.out_valid), 0);

    // random traffic; requester holds a refused request
    v = 0; op = 0; f = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!(bus.in_valid && !last_acc)) begin
        v = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 1) == 0) op = 2;
        else op = int'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0)
          f = int'($urandom_range(0, 63));
        else
          f = fl[$urandom_range(0, 15)];
      end
      drive(v, op, f, ($urandom_range(0, 9) < 7));
      step();
    end
    drive(0, 0, 0, 1);
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_ctl_seq.md
Name: alu_ctl_seq

Overview:
Parametrised, registered successor to the combinational ALU control decoder.
- Accepts {ALUOp, FuncCode} through a valid/ready handshake and produces a registered ALU control code.
- Adds multi-cycle sequencing for mult/multu/div/divu (HI/LO unit) with a busy countdown.
- Sits between the control unit and the ALU/muldiv unit in the datapath; stalls issue while a long op is in flight.

Parameters:
- OP_W, 4, width of ALUOp.
- FUNCT_W, 6, width of FuncCode.
- CTL_W, 4, width of control code; must be >= 4.
- MULT_CYCLES, 4, total latency of mult/multu, accept to out_valid, including the accept cycle; range 2..255.
- DIV_CYCLES, 8, total latency of div/divu, accept to out_valid; range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- alu_op  in  OP_W  ALUOp from the control unit.
- func_code  in  FUNCT_W  instruction funct field.
- out_valid  out  1  out_ctl valid.
- out_ready  in  1  consumer accepts out_ctl.
- out_ctl  out  CTL_W  ALU control code.
- out_muldiv  out  1  code targets the muldiv unit (multi-cycle op).
- busy  out  1  multi-cycle op in progress.
- illegal  out  1  decoded request was unrecognised (qualified by out_valid).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, out_ctl=0, out_muldiv=0, busy=0, illegal=0, counter=0.
- Handshake:
  - Transfer on in_valid&&in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Output held stable while out_valid && !out_ready.
- Decode table, by ALUOp:
  - 0 -> 2 (lw/sw)
  - 1 -> 6 (beq)
  - 3 -> 2 (addi)
  - 4 -> 7 (slti)
  - 5 -> 0 (andi)
  - 6 -> 1 (ori)
  - 7 -> 11 (lui)
- Decode table, ALUOp=2, by funct:
  - 0/2/8 -> 15 (sll/srl/jr)
  - 32/33 -> 2
  - 34/35 -> 6
  - 36 -> 0
  - 37 -> 1
  - 39 -> 12
  - 42 -> 7
  - 43 -> 15
  - 24/25 -> 13 (mult/multu), muldiv
  - 26/27 -> 14 (div/divu), muldiv
  - any other funct -> 15, illegal=1
- ALUOp 8..2^OP_W-1 -> 15, illegal=1.
- Codes are zero-extended to CTL_W.
- States:
  - IDLE: on transfer of a simple op -> out_ctl/illegal registered, out_valid=1 next cycle (latency 1), stay IDLE.
  - IDLE: on transfer of a muldiv op -> counter=MULT_CYCLES-2 or DIV_CYCLES-2, busy=1, -> BUSY. The funct bit that distinguishes mult from div is latched at accept.
  - BUSY: counter decrements each cycle. At counter==0: out_valid=1, out_ctl=13/14, out_muldiv=1, busy=0, -> IDLE.
  - Total latency from the accept edge to out_valid = MULT_CYCLES or DIV_CYCLES.
- out_valid clears on out_ready if no new transfer occurs the same cycle.
- Back-to-back simple ops with out_ready=1 sustain 1 op/cycle.
- in_valid during BUSY is ignored (in_ready=0); the requester holds its inputs.
- BUSY completion with a stale out_valid && !out_ready cannot occur: entry to BUSY requires the output slot free-or-draining. A slot freed by a simultaneous out_ready is treated as free.
- rst_n asserted mid-BUSY: immediate return to IDLE; the pending op is discarded with no out_valid.
- out_muldiv=0 for all simple ops.

Optional Feature:
- Macro ALU_CTL_STICKY_ERR_EN.
- Defined:
  - Adds output err_sticky (1 bit), set on any accepted illegal request and cleared only by reset.
  - Illegal requests are still emitted (code 15).
- Undefined:
  - err_sticky port absent.
  - illegal is the per-output flag only.

Test Plan:
1. Reset, then alu_op=2/funct=32 with in_valid 1 cycle, out_ready=1 -> next cycle out_valid=1, out_ctl=2, illegal=0, out_muldiv=0.
2. Stream ALUOp 0,1,3,4,5,6,7 back-to-back, out_ready=1 -> in_ready stays 1; outputs 2,6,2,7,0,1,11 on consecutive cycles.
3. alu_op=2/funct=24, MULT_CYCLES=4 -> busy=1 and in_ready=0 for the intervening cycles. A second request held on in_valid is not accepted. out_valid with out_ctl=13, out_muldiv=1 exactly 4 cycles after accept; the second request is accepted the next cycle.
4. funct=26, out_ready=0 at completion -> out_ctl=14 held until out_ready=1; in_ready=0 meanwhile.
5. alu_op=2/funct=50, then alu_op=9 -> out_ctl=15, illegal=1 both. With ALU_CTL_STICKY_ERR_EN: err_sticky=1 persists until rst_n.
6. Assert rst_n=0 on the 2nd cycle of a div -> busy, out_valid drop asynchronously. After release: IDLE, in_ready=1, no spurious out_valid.
